csr_file: RTL

- Machine-mode CSR register file; its read data drives the csr_rd input of the writeback select mux.
- Executes CSRRW/CSRRS/CSRRC for the decoder/FSM.
- Records trap entry and MRET, and synchronises the external interrupt line.
- Supplies MTVEC/MEPC to the PC source mux and a qualified interrupt request to the control FSM.

---
 rtl/csr_pkg.sv | 42 ++++
 rtl/csr_file_if.sv | 29 ++
 rtl/csr_counter64.sv | 45 ++++
 rtl/csr_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, operation
// encoding, implemented bit positions and the read-modify-write helper.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MEIE_BIT = 11;
    localparam int MEIP_BIT = 11;

    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_val, logic [31:0] wd);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = wd;
            CSR_RS:  res = old_val | wd;
            CSR_RC:  res = old_val & ~wd;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// Core-side bus of the CSR file: CSR access, trap/MRET/retire events and
// the vector/interrupt outputs consumed by the PC mux and control FSM.
interface csr_file_if;
    import csr_pkg::*;

    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    csr_op_t     csr_op;
    logic        csr_we;
    logic [31:0] csr_rd;
    logic        illegal;
    logic [31:0] pc;
    logic        trap_taken;
    logic        mret;
    logic        instr_retire;
    logic        int_req;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    modport master (
        output csr_addr, csr_wd, csr_op, csr_we, pc, trap_taken, mret, instr_retire,
        input  csr_rd, illegal, int_req, mtvec, mepc
    );

    modport slave (
        input  csr_addr, csr_wd, csr_op, csr_we, pc, trap_taken, mret, instr_retire,
        output csr_rd, illegal, int_req, mtvec, mepc
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter built from two software-writable 32-bit halves; a write to
// a half takes the place of that half's increment on that edge.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wd,
    output logic [63:0] value
);
    logic [31:0] lo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_next_s;
    logic [31:0] hi_next_s;
    logic        carry_s;

    // Next value for each half; a written low half produces no carry
    always_comb begin
        carry_s = inc_en & ~we_lo & (lo_r == 32'hFFFF_FFFF);
        if (we_lo) begin
            lo_next_s = wd;
        end else begin
            lo_next_s = lo_r + {31'd0, inc_en};
        end
        if (we_hi) begin
            hi_next_s = wd;
        end else begin
            hi_next_s = hi_r + {31'd0, carry_s};
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= 32'd0;
            hi_r <= 32'd0;
        end else begin
            lo_r <= lo_next_s;
            hi_r <= hi_next_s;
        end
    end

    assign value = {hi_r, lo_r};
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file: CSRRW/RS/RC execution, trap entry and MRET
// bookkeeping, cycle/instret counters and the synchronised external interrupt.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      intr,
    csr_file_if.slave bus
);
    logic                   mstatus_mie_r;
    logic                   mstatus_mpie_r;
    logic                   mie_meie_r;
    logic [31:0]            mtvec_r;
    logic [31:0]            mscratch_r;
    logic [31:0]            mepc_r;
    logic [31:0]            mcause_r;
    logic [SYNC_STAGES-1:0] sync_r;

    logic        meip_s;
    logic        legal_s;
    logic        illegal_s;
    logic        wr_s;
    logic [31:0] rd_s;
    logic [31:0] new_s;
    logic        mie_next_s;
    logic        mpie_next_s;
    logic [31:0] mepc_next_s;
    logic [31:0] mcause_next_s;
    logic [63:0] mcycle_s;
    logic [63:0] minstret_s;

    assign meip_s = sync_r[SYNC_STAGES-1];

    // Address decode and read mux; reads return the pre-update value
    always_comb begin
        legal_s = 1'b1;
        rd_s    = 32'd0;
        case (bus.csr_addr)
            CSR_MSTATUS: begin
                rd_s[MIE_BIT]  = mstatus_mie_r;
                rd_s[MPIE_BIT] = mstatus_mpie_r;
            end
            CSR_MIE:       rd_s[MEIE_BIT] = mie_meie_r;
            CSR_MTVEC:     rd_s = mtvec_r;
            CSR_MSCRATCH:  rd_s = mscratch_r;
            CSR_MEPC:      rd_s = mepc_r;
            CSR_MCAUSE:    rd_s = mcause_r;
            CSR_MIP:       rd_s[MEIP_BIT] = meip_s;
            CSR_MCYCLE:    rd_s = mcycle_s[31:0];
            CSR_MCYCLEH:   rd_s = mcycle_s[63:32];
            CSR_MINSTRET:  rd_s = minstret_s[31:0];
            CSR_MINSTRETH: rd_s = minstret_s[63:32];
            default:       legal_s = 1'b0;
        endcase
    end

    // An RS/RC with a zero operand still counts as a write to mip
    assign illegal_s = ~legal_s | ((bus.csr_addr == CSR_MIP) & bus.csr_we);
    assign wr_s      = bus.csr_we & (bus.csr_op != CSR_NONE) & ~illegal_s;
    assign new_s     = csr_apply(bus.csr_op, rd_s, bus.csr_wd);

    // mstatus next state: trap beats MRET beats a CSR write
    always_comb begin
        mie_next_s  = mstatus_mie_r;
        mpie_next_s = mstatus_mpie_r;
        if (bus.trap_taken) begin
            mpie_next_s = mstatus_mie_r;
            mie_next_s  = 1'b0;
        end else if (bus.mret) begin
            mie_next_s  = mstatus_mpie_r;
            mpie_next_s = 1'b1;
        end else if (wr_s && (bus.csr_addr == CSR_MSTATUS)) begin
            mie_next_s  = new_s[MIE_BIT];
            mpie_next_s = new_s[MPIE_BIT];
        end else begin
            mie_next_s  = mstatus_mie_r;
            mpie_next_s = mstatus_mpie_r;
        end
    end

    // mepc/mcause next state: trap entry overrides a coincident write
    always_comb begin
        mepc_next_s   = mepc_r;
        mcause_next_s = mcause_r;
        if (bus.trap_taken) begin
            mepc_next_s   = bus.pc & ALIGN4_MASK;
            mcause_next_s = MCAUSE_EXT_INT;
        end else begin
            if (wr_s && (bus.csr_addr == CSR_MEPC)) begin
                mepc_next_s = new_s & ALIGN4_MASK;
            end else begin
                mepc_next_s = mepc_r;
            end
            if (wr_s && (bus.csr_addr == CSR_MCAUSE)) begin
                mcause_next_s = new_s;
            end else begin
                mcause_next_s = mcause_r;
            end
        end
    end

    // CSR state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_meie_r     <= 1'b0;
            mtvec_r        <= 32'd0;
            mscratch_r     <= 32'd0;
            mepc_r         <= 32'd0;
            mcause_r       <= 32'd0;
        end else begin
            mstatus_mie_r  <= mie_next_s;
            mstatus_mpie_r <= mpie_next_s;
            mepc_r         <= mepc_next_s;
            mcause_r       <= mcause_next_s;
            if (wr_s && (bus.csr_addr == CSR_MIE)) begin
                mie_meie_r <= new_s[MEIE_BIT];
            end
            if (wr_s && (bus.csr_addr == CSR_MTVEC)) begin
                mtvec_r <= new_s & ALIGN4_MASK;
            end
            if (wr_s && (bus.csr_addr == CSR_MSCRATCH)) begin
                mscratch_r <= new_s;
            end
        end
    end

    // External interrupt synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], intr};
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (1'b1),
        .we_lo  (wr_s && (bus.csr_addr == CSR_MCYCLE)),
        .we_hi  (wr_s && (bus.csr_addr == CSR_MCYCLEH)),
        .wd     (new_s),
        .value  (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (bus.instr_retire),
        .we_lo  (wr_s && (bus.csr_addr == CSR_MINSTRET)),
        .we_hi  (wr_s && (bus.csr_addr == CSR_MINSTRETH)),
        .wd     (new_s),
        .value  (minstret_s)
    );

    assign bus.csr_rd  = rd_s;
    assign bus.illegal = illegal_s;
    assign bus.int_req = meip_s & mstatus_mie_r & mie_meie_r;
    assign bus.mtvec   = mtvec_r;
    assign bus.mepc    = mepc_r;
endmodule
